// File: rtl/sd_adc_rx.sv
// -----------------------------------------------------------------------------
// sd_adc_rx -- receive side of a first-order 1-bit sigma-delta ADC.
//
// An external comparator samples the RC-filtered input against the feedback
// bit. This block synchronises the comparator output, registers it as the
// feedback bit o_fb, and decimates the resulting bitstream with a second-order
// CIC (sinc2) filter. The output is unsigned PCM, and each sample comes with a
// one-cycle valid strobe.
//
// Optional build macro: SD_ADC_PEAK_EN
//   defined   : o_peak tracks the maximum sample since the last i_peak_clr.
//   undefined : o_peak is tied to 0, and i_peak_clr is ignored.
//
// Parameters
//   DECIM_LOG2 : log2 of the decimation ratio R (legal 2..12).
//   OUT_W      : output sample width (<= 2*DECIM_LOG2).
//
// Ports
//   i_clk        system clock (9 MHz)
//   i_res_n      asynchronous active-low reset
//   i_cmp        comparator output, asynchronous to i_clk
//   i_en         conversion enable
//   i_peak_clr   clears the peak register (peak build only)
//   o_fb         feedback bit to the RC network
//   o_data       unsigned PCM sample, mid-scale = 2^(OUT_W-1)
//   o_valid      one-cycle strobe; o_data is new in the same cycle
//   o_overrange  set with o_valid when the sample saturated
//   o_peak       maximum sample since the last clear
// -----------------------------------------------------------------------------
module sd_adc_rx #(
  parameter int DECIM_LOG2 = 8,
  parameter int OUT_W      = 8
) (
  input  logic             i_clk,
  input  logic             i_res_n,
  input  logic             i_cmp,
  input  logic             i_en,
  input  logic             i_peak_clr,
  output logic             o_fb,
  output logic [OUT_W-1:0] o_data,
  output logic             o_valid,
  output logic             o_overrange,
  output logic [OUT_W-1:0] o_peak
);

  // Accumulator width: the sinc2 output spans 0..R^2, which needs 2*log2(R)+1 bits.
  localparam int ACC_W = 2 * DECIM_LOG2 + 1;

  localparam logic [DECIM_LOG2-1:0] CNT_ZERO   = {DECIM_LOG2{1'b0}};
  localparam logic [DECIM_LOG2-1:0] CNT_ONE    = {{(DECIM_LOG2-1){1'b0}}, 1'b1};
  localparam logic [DECIM_LOG2-1:0] CNT_LAST   = {DECIM_LOG2{1'b1}};
  localparam logic [ACC_W-1:0]      ACC_ZERO   = {ACC_W{1'b0}};
  localparam logic [ACC_W-1:0]      FULL_SCALE = {1'b1, {(2*DECIM_LOG2){1'b0}}};
  localparam logic [OUT_W-1:0]      OUT_ZERO   = {OUT_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2
  } state_e;

  // Saturating quantiser: returns {overrange, sample}. The only value of y
  // that reaches R^2 is the all-ones input, and it saturates.
  function automatic logic [OUT_W:0] quantize(input logic [ACC_W-1:0] y);
    logic [OUT_W:0] r;
    if (y >= FULL_SCALE) begin
      r = {1'b1, {OUT_W{1'b1}}};
    end else begin
      r = {1'b0, y[2*DECIM_LOG2-1 -: OUT_W]};
    end
    return r;
  endfunction

  // Synchroniser and feedback register
  logic sync1_q, sync2_q, fb_q;

  // Decimation counter, integrators and comb history
  logic [DECIM_LOG2-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0]      int1_q, int1_d;
  logic [ACC_W-1:0]      int2_q, int2_d;
  logic [ACC_W-1:0]      cz1_q, cz1_d;
  logic [ACC_W-1:0]      d1z1_q, d1z1_d;

  // Comb datapath (combinational, evaluated on every clock)
  logic [ACC_W-1:0]      c_s, d1_s, y_s;
  logic [OUT_W:0]        q_s;
  logic                  dump_s;

  // Control
  state_e                state_q, state_d;
  logic                  warm_q, warm_d;
  logic                  arm_s;

  // Output registers
  logic [OUT_W-1:0]      data_q, data_d;
  logic                  ovr_q, ovr_d;
  logic                  valid_q, valid_d;

  // Two-flop synchroniser followed by the feedback flop. It runs in every state so the analog loop stays settled.
  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      fb_q    <= 1'b0;
    end else begin
      sync1_q <= i_cmp;
      sync2_q <= sync1_q;
      fb_q    <= sync2_q;
    end
  end

  // A dump happens on the last counted clock of each R-clock window.
  always_comb begin
    dump_s = i_en && (cnt_q == CNT_LAST);
  end

  // Comb stage: second difference of int2, taken at the decimated rate.
  always_comb begin
    c_s  = int2_q;
    d1_s = c_s - cz1_q;
    y_s  = d1_s - d1z1_q;
    q_s  = quantize(y_s);
  end

  // Next state of the counter, integrators and comb history. Everything is held at zero while the block is disabled.
  always_comb begin
    cnt_d  = cnt_q;
    int1_d = int1_q;
    int2_d = int2_q;
    cz1_d  = cz1_q;
    d1z1_d = d1z1_q;
    if (!i_en) begin
      cnt_d  = CNT_ZERO;
      int1_d = ACC_ZERO;
      int2_d = ACC_ZERO;
      cz1_d  = ACC_ZERO;
      d1z1_d = ACC_ZERO;
    end else begin
      cnt_d  = cnt_q + CNT_ONE;
      int1_d = int1_q + {{(ACC_W-1){1'b0}}, fb_q};
      int2_d = int2_q + int1_q;
      if (dump_s) begin
        cz1_d  = c_s;
        d1z1_d = d1_s;
      end else begin
        cz1_d  = cz1_q;
        d1z1_d = d1z1_q;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      cnt_q  <= CNT_ZERO;
      int1_q <= ACC_ZERO;
      int2_q <= ACC_ZERO;
      cz1_q  <= ACC_ZERO;
      d1z1_q <= ACC_ZERO;
    end else begin
      cnt_q  <= cnt_d;
      int1_q <= int1_d;
      int2_q <= int2_d;
      cz1_q  <= cz1_d;
      d1z1_q <= d1z1_d;
    end
  end

  // FSM state register, plus the counter of dumps seen during warm-up.
  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      state_q <= ST_IDLE;
      warm_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      warm_q  <= warm_d;
    end
  end

  // FSM next state. Warm-up absorbs two dumps so the comb history holds real data.
  always_comb begin
    state_d = state_q;
    warm_d  = warm_q;
    case (state_q)
      ST_IDLE: begin
        warm_d = 1'b0;
        if (i_en) begin
          state_d = ST_WARMUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WARMUP: begin
        if (!i_en) begin
          state_d = ST_IDLE;
          warm_d  = 1'b0;
        end else if (dump_s && warm_q) begin
          state_d = ST_RUN;
          warm_d  = 1'b0;
        end else if (dump_s) begin
          state_d = ST_WARMUP;
          warm_d  = 1'b1;
        end else begin
          state_d = ST_WARMUP;
          warm_d  = warm_q;
        end
      end
      ST_RUN: begin
        warm_d = 1'b0;
        if (!i_en) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        warm_d  = 1'b0;
      end
    endcase
  end

  // FSM outputs. Only a dump taken in RUN arms a strobe.
  always_comb begin
    case (state_q)
      ST_RUN:  arm_s = dump_s;
      ST_IDLE,
      ST_WARMUP: arm_s = 1'b0;
      default: arm_s = 1'b0;
    endcase
  end

  // Next state of the output registers. The sample and the overrange flag hold between strobes.
  always_comb begin
    data_d  = data_q;
    ovr_d   = ovr_q;
    valid_d = 1'b0;
    if (arm_s) begin
      data_d  = q_s[OUT_W-1:0];
      ovr_d   = q_s[OUT_W];
      valid_d = 1'b1;
    end else begin
      data_d  = data_q;
      ovr_d   = ovr_q;
      valid_d = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      data_q  <= OUT_ZERO;
      ovr_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      ovr_q   <= ovr_d;
      valid_q <= valid_d;
    end
  end

  assign o_fb        = fb_q;
  assign o_data      = data_q;
  assign o_overrange = ovr_q;
  // A strobe armed by the previous dump must disappear if i_en falls in the
  // strobe cycle itself, so the final gate on i_en is combinational.
  assign o_valid     = valid_q & i_en;

`ifdef SD_ADC_PEAK_EN
  logic [OUT_W-1:0] peak_q, peak_d;

  // Peak tracker. The clear wins over the max compare, but a clear that
  // coincides with a strobe loads the new sample.
  always_comb begin
    peak_d = peak_q;
    if (i_peak_clr) begin
      if (o_valid) begin
        peak_d = data_q;
      end else begin
        peak_d = OUT_ZERO;
      end
    end else if (o_valid && (data_q > peak_q)) begin
      peak_d = data_q;
    end else begin
      peak_d = peak_q;
    end
  end

  // Peak register.
  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      peak_q <= OUT_ZERO;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign o_peak = peak_q;
`else
  logic peak_clr_unused_s;

  assign peak_clr_unused_s = i_peak_clr;
  assign o_peak            = OUT_ZERO;
`endif

endmodule
